// File: rtl/udp_pkg.sv
// Shared types and constants for the programmable truth-table engine.
package udp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } cfg_state_e;

    localparam logic [7:0] DEF_TABLE3 = 8'hD5;

endpackage

// File: rtl/lut_cfg_loader.sv
// Serial truth-table loader: shifts config bits into a shadow register and
// strobes commit with the completed table on the final beat.
module lut_cfg_loader
    import udp_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_valid,
    input  logic                 cfg_bit,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    output logic                 commit,
    output logic [2**N_IN-1:0]   commit_table
);

    localparam int              DEPTH     = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_BEAT = '1;

    cfg_state_e        state_q, state_d;
    logic [N_IN-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]  shadow_q, shadow_d;
    logic              done_q, done_d;

    // NOTE: every output of this block gets a default before any branch, so no path can leave a latch behind.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        commit       = 1'b0;
        commit_table = shadow_q;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            LOAD: begin
                // A restart takes priority over a beat arriving in the same cycle.
                if (cfg_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (cfg_valid) begin
                    shadow_d[cnt_q] = cfg_bit;
                    cnt_d           = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        commit       = 1'b1;
                        commit_table = shadow_d;
                        state_d      = IDLE;
                        cnt_d        = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = commit;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the shadow is a handful of flops, not a RAM, so it is cheap to reset alongside the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
        end
    end

    assign cfg_busy = (state_q == LOAD);
    assign cfg_done = done_q;

endmodule

// File: rtl/lut_udp_engine.sv
// Runtime-programmable N-input truth-table evaluator with a 2-stage
// valid/ready pipeline, an AND-gated output and a saturating hit counter.
module lut_udp_engine
    import udp_pkg::*;
#(
    parameter int                 N_IN      = 3,
    parameter logic [2**N_IN-1:0] DEF_TABLE = DEF_TABLE3,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    output logic              cfg_busy,
    output logic              cfg_done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_x,
    input  logic              in_gate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_d,
    output logic              out_f,
    input  logic              hit_clr,
    output logic [CNT_W-1:0]  hit_count
);

    localparam int DEPTH = 2**N_IN;

    logic              commit;
    logic [DEPTH-1:0]  commit_table;

    logic [DEPTH-1:0]  table_q, table_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_d_q, s1_d_d;
    logic              s1_gate_q, s1_gate_d;
    logic              out_valid_q, out_valid_d;
    logic              out_d_q, out_d_d;
    logic              out_f_q, out_f_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic              stall, accept;

    lut_cfg_loader #(.N_IN(N_IN)) u_cfg_loader (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_valid    (cfg_valid),
        .cfg_bit      (cfg_bit),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .commit       (commit),
        .commit_table (commit_table)
    );

    assign stall  = out_valid_q & ~out_ready;
    assign accept = in_valid & ~stall;

    always_comb begin
        table_d     = commit ? commit_table : table_q;
        s1_valid_d  = s1_valid_q;
        s1_d_d      = s1_d_q;
        s1_gate_d   = s1_gate_q;
        out_valid_d = out_valid_q;
        out_d_d     = out_d_q;
        out_f_d     = out_f_q;
        hit_d       = hit_q;

        // Global stall: both stages hold together. Bubbles carry zero data
        // so the outputs stay clean whenever out_valid is low.
        if (!stall) begin
            s1_valid_d  = accept;
            s1_d_d      = accept & table_q[in_x];
            s1_gate_d   = accept & in_gate;
            out_valid_d = s1_valid_q;
            out_d_d     = s1_d_q;
            out_f_d     = s1_d_q & s1_gate_q;
        end

        if (hit_clr) begin
            hit_d = '0;
        end else if (out_valid_q && out_ready && out_f_q && (hit_q != {CNT_W{1'b1}})) begin
            hit_d = hit_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            table_q     <= DEF_TABLE;
            s1_valid_q  <= 1'b0;
            s1_d_q      <= 1'b0;
            s1_gate_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_d_q     <= 1'b0;
            out_f_q     <= 1'b0;
            hit_q       <= '0;
        end else begin
            table_q     <= table_d;
            s1_valid_q  <= s1_valid_d;
            s1_d_q      <= s1_d_d;
            s1_gate_q   <= s1_gate_d;
            out_valid_q <= out_valid_d;
            out_d_q     <= out_d_d;
            out_f_q     <= out_f_d;
            hit_q       <= hit_d;
        end
    end

    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign out_d     = out_d_q;
    assign out_f     = out_f_q;
    assign hit_count = hit_q;

endmodule
